// File: rtl/ram_access_arbiter.sv
// ============================================================================
// Module: ram_access_arbiter
//
// Purpose
//   Shares one single-port synchronous RAM between two requesters:
//     port A - instruction fetch
//     port B - load/store
//   One access takes four cycles: IDLE -> ISSUE -> CAPTURE -> ACK.
//     IDLE    : pick a winner and latch its command into the ram_* registers.
//     ISSUE   : ram_enable is high for exactly this cycle. The RAM acts on
//               the edge that closes it.
//     CAPTURE : the RAM read data is valid. For a read it is loaded into the
//               owner's data_out, and the owner's ack is raised.
//     ACK     : the owner's ack is high for this one cycle.
//   If a request is seen in IDLE cycle T0, the ack and read data are visible
//   in cycle T3.
//
// Handshake
//   A requester raises req with a stable command (rw/address/data_in) and
//   holds all of them until it sees ack=1 for one cycle. At the edge that ends
//   the ack cycle it either drops req or presents the next command. A req seen
//   high in IDLE is always treated as a new request. The command is latched at
//   grant, so any later change on either port does not affect the access in
//   flight.
//
// Configuration
//   RAM_ARB_ROUND_ROBIN_EN : when defined, a tie goes to the port that was not
//                            served last. last_served resets to B, so A wins
//                            the first tie. When undefined, B always beats A
//                            and no last_served state exists.
//
// Parameters
//   ADDRESS_WIDTH : width of all address buses
//   DATA_WIDTH    : width of all data buses
//
// Ports
//   clock                 in   sole clock; all state changes on posedge
//   reset_n               in   asynchronous active-low reset
//   a_req / b_req         in   request, held until the matching ack
//   a_rw / b_rw           in   0 = read, 1 = write
//   a_address / b_address in   access address
//   a_data_in / b_data_in in   write data
//   a_ack / b_ack         out  one-cycle completion pulse
//   a_data_out/b_data_out out  read data; valid with ack, held until the next
//                              read on the same port
//   ram_enable            out  RAM enable (high only in ISSUE)
//   ram_rw                out  RAM read/write select
//   ram_address           out  RAM address
//   ram_data_in           out  RAM write data
//   ram_data_out          in   RAM read data (registered, 1-cycle latency)
//   busy                  out  high in every state other than IDLE
//   dbg_state             out  current FSM state encoding, for observation
//
// Every output is driven straight from a register. Asserting reset_n clears
// them asynchronously. Reset during ISSUE therefore drops ram_enable at once,
// and the RAM edge that closes ISSUE sees no enable, so no write happens.
// ============================================================================
module ram_access_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     a_req,
    input  logic                     a_rw,
    input  logic [ADDRESS_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0]    a_data_in,
    output logic                     a_ack,
    output logic [DATA_WIDTH-1:0]    a_data_out,

    input  logic                     b_req,
    input  logic                     b_rw,
    input  logic [ADDRESS_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0]    b_data_in,
    output logic                     b_ack,
    output logic [DATA_WIDTH-1:0]    b_data_out,

    output logic                     ram_enable,
    output logic                     ram_rw,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,

    output logic                     busy,
    output logic [1:0]               dbg_state
);

    // ------------------------------------------------------------------
    // State encoding and owner identifiers
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     r_owner;
    logic                     r_ram_enable;
    logic                     r_ram_rw;
    logic [ADDRESS_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0]    r_ram_data_in;
    logic                     r_a_ack;
    logic                     r_b_ack;
    logic [DATA_WIDTH-1:0]    r_a_data_out;
    logic [DATA_WIDTH-1:0]    r_b_data_out;
    logic                     r_busy;

    logic                     w_any_req;
    logic                     w_grant_b;

    assign w_any_req = a_req | b_req;

    // ------------------------------------------------------------------
    // Arbitration: w_grant_b is high when port B wins this IDLE cycle.
    // It is used only while w_any_req is high. A single requester always
    // wins, whatever the arbitration history.
    // ------------------------------------------------------------------
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic r_last_served;

    // On a tie, B wins only if A was served last.
    assign w_grant_b = b_req & (~a_req | (r_last_served == OWNER_A));

    // Updated at grant, which is the IDLE -> ISSUE edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_served <= OWNER_B;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_last_served <= w_grant_b;
        end
    end
`else
    // Fixed priority: B beats A.
    assign w_grant_b = b_req;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:   w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_ACK;
            ST_ACK:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and RAM drive. The winner's command is copied here
    // only at grant, so later changes on either port are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner       <= OWNER_A;
            r_ram_enable  <= 1'b0;
            r_ram_rw      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner       <= w_grant_b;
                        r_ram_enable  <= 1'b1;
                        r_ram_rw      <= w_grant_b ? b_rw      : a_rw;
                        r_ram_address <= w_grant_b ? b_address : a_address;
                        r_ram_data_in <= w_grant_b ? b_data_in : a_data_in;
                    end else begin
                        r_ram_enable  <= 1'b0;
                    end
                end
                // The RAM acts on the edge that closes ISSUE, so enable
                // drops on that same edge.
                default: begin
                    r_ram_enable <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response path. In CAPTURE the RAM output holds the word read during
    // ISSUE. Only the owner's ack and data_out are touched, and data_out
    // changes only for a read.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_a_data_out <= '0;
            r_b_data_out <= '0;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    if (r_owner == OWNER_B) begin
                        r_b_ack <= 1'b1;
                        if (!r_ram_rw) begin
                            r_b_data_out <= ram_data_out;
                        end
                    end else begin
                        r_a_ack <= 1'b1;
                        if (!r_ram_rw) begin
                            r_a_data_out <= ram_data_out;
                        end
                    end
                end
                default: begin
                    // The ack pulse lasts for the ACK cycle only.
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // busy is registered from the next state, so it tracks the state
    // register exactly and still comes straight off a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_enable  = r_ram_enable;
    assign ram_rw      = r_ram_rw;
    assign ram_address = r_ram_address;
    assign ram_data_in = r_ram_data_in;
    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign a_data_out  = r_a_data_out;
    assign b_data_out  = r_b_data_out;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_ack_b_ack_exclusive: assert property (
        @(posedge clock) disable iff (!reset_n) !(r_a_ack && r_b_ack));

    ram_enable_only_in_issue: assert property (
        @(posedge clock) disable iff (!reset_n) (r_ram_enable == (r_state == ST_ISSUE)));

    busy_matches_state: assert property (
        @(posedge clock) disable iff (!reset_n) (r_busy == (r_state != ST_IDLE)));

endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 20;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam int TIE_LAT_A = 3;
    localparam int TIE_LAT_B = 7;
`else
    localparam int TIE_LAT_A = 7;
    localparam int TIE_LAT_B = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          a_req, a_rw, a_ack;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_data_in, a_data_out;
    logic          b_req, b_rw, b_ack;
    logic [AW-1:0] b_address;
    logic [DW-1:0] b_data_in, b_data_out;
    logic          ram_enable, ram_rw;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          busy;
    logic [1:0]    dbg_state;

    ram_access_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_req        (a_req),
        .a_rw         (a_rw),
        .a_address    (a_address),
        .a_data_in    (a_data_in),
        .a_ack        (a_ack),
        .a_data_out   (a_data_out),
        .b_req        (b_req),
        .b_rw         (b_rw),
        .b_address    (b_address),
        .b_data_in    (b_data_in),
        .b_ack        (b_ack),
        .b_data_out   (b_data_out),
        .ram_enable   (ram_enable),
        .ram_rw       (ram_rw),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- RAM model (registered read, write at enable edge) ----------------
    logic [DW-1:0] mem [0:65535];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_enable) begin
            if (ram_rw) mem[ram_address] <= ram_data_in;
            else        ram_data_out     <= mem[ram_address];
        end
    end

    // ---------------- scoreboard state ----------------
    int            checks   = 0;
    int            failures = 0;
    int            en_count = 0;
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    int            exp_a_cyc_q[$];
    int            exp_b_cyc_q[$];
    logic [DW-1:0] model_a, model_b;   // data_out each port should show after its pending ack
    logic [DW-1:0] held_a, held_b;     // data_out each port shows now

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_loop();
        logic [DW-1:0] ed;
        int            ec;
        forever begin
            @(negedge clock);
            if (ram_enable) en_count++;
            if (a_ack && b_ack) begin
                checks++; failures++;
                $display("FAIL ack_overlap: a_ack=1 and b_ack=1 in cycle %0d", cyc);
            end
            if (a_ack) begin
                if (exp_a_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_ack_unexpected: a_ack=1 with nothing pending (cycle %0d)", cyc);
                end else begin
                    ed = exp_a_q.pop_front();
                    ec = exp_a_cyc_q.pop_front();
                    check("a_data_out", a_data_out, ed);
                    check("a_ack_cycle", cyc, ec);
                    check("b_data_out_undisturbed", b_data_out, held_b);
                    held_a = ed;
                end
            end
            if (b_ack) begin
                if (exp_b_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_ack_unexpected: b_ack=1 with nothing pending (cycle %0d)", cyc);
                end else begin
                    ed = exp_b_q.pop_front();
                    ec = exp_b_cyc_q.pop_front();
                    check("b_data_out", b_data_out, ed);
                    check("b_ack_cycle", cyc, ec);
                    check("a_data_out_undisturbed", a_data_out, held_a);
                    held_b = ed;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(posedge clock); #1;
        pre_we = 1'b0;
    endtask

    // Called at posedge+1, so the current cycle is T0. Expected ack cycle is T0+lat.
    task automatic issue(input bit port_b, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input int lat);
        if (port_b) begin
            if (!rw) model_b = rdata;
            exp_b_q.push_back(model_b);
            exp_b_cyc_q.push_back(cyc + lat);
            b_rw = rw; b_address = addr; b_data_in = wdata; b_req = 1'b1;
        end else begin
            if (!rw) model_a = rdata;
            exp_a_q.push_back(model_a);
            exp_a_cyc_q.push_back(cyc + lat);
            a_rw = rw; a_address = addr; a_data_in = wdata; a_req = 1'b1;
        end
    endtask

    task automatic wait_release(input bit port_b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            @(negedge clock);
            seen = port_b ? b_ack : a_ack;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_ack_timeout: no ack within %0d cycles", port_b ? "b" : "a", TMO);
        end
        @(posedge clock); #1;
        if (port_b) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic access(input bit port_b, input logic rw, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input int lat);
        issue(port_b, rw, addr, wdata, rdata, lat);
        wait_release(port_b);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int e0;
    int t_start;

    initial begin
        fork
            monitor_loop();
        join_none

        reset_n = 1'b0;
        a_req = 0; a_rw = 0; a_address = '0; a_data_in = '0;
        b_req = 0; b_rw = 0; b_address = '0; b_data_in = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        model_a = '0; model_b = '0; held_a = '0; held_b = '0;

        preload(16'h0010, 16'hBEEF);
        preload(16'h0050, 16'h5050);
        preload(16'h0051, 16'h5151);
        preload(16'h0001, 16'h1111);
        preload(16'h0002, 16'h2222);
        preload(16'h0003, 16'h3333);
        preload(16'h0030, 16'h5555);
        preload(16'h0040, 16'h4040);
        preload(16'h0041, 16'h4141);

        // Reset values
        @(negedge clock);
        check("rst_ram_enable", ram_enable, 0);
        check("rst_ram_rw", ram_rw, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_data_in", ram_data_in, 0);
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        check("rst_a_data_out", a_data_out, 0);
        check("rst_b_data_out", b_data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);

        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Tie with fresh arbitration history
        e0 = en_count;
        fork
            access(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h5050, TIE_LAT_A);
            access(1'b1, 1'b0, 16'h0051, 16'h0000, 16'h5151, TIE_LAT_B);
        join
        check("tie_enable_pulses", en_count - e0, 2);

        // A read only: enable only in T1
        e0 = en_count;
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3);
        @(negedge clock);
        check("rdA_en_T0", ram_enable, 0);
        check("rdA_busy_T0", busy, 0);
        @(negedge clock);
        check("rdA_en_T1", ram_enable, 1);
        check("rdA_busy_T1", busy, 1);
        check("rdA_addr_T1", ram_address, 16'h0010);
        @(negedge clock);
        check("rdA_en_T2", ram_enable, 0);
        wait_release(1'b0);
        check("rdA_enable_pulses", en_count - e0, 1);

        // B write then A read of the same word
        access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, 3);
        check("wrB_mem_0x20", mem[16'h0020], 16'h1234);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3);

        // Back-to-back A reads, req held, command changed after each ack
        e0 = en_count;
        t_start = cyc;
        access(1'b0, 1'b0, 16'h0001, 16'h0000, 16'h1111, 3);
        access(1'b0, 1'b0, 16'h0002, 16'h0000, 16'h2222, 3);
        access(1'b0, 1'b0, 16'h0003, 16'h0000, 16'h3333, 3);
        check("b2b_enable_pulses", en_count - e0, 3);
        check("b2b_total_cycles", cyc - t_start, 12);

        // Command change after grant is ignored
        issue(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h4040, 3);
        @(posedge clock); #1;
        a_address = 16'h0041; a_rw = 1'b1; a_data_in = 16'hDEAD;
        @(negedge clock);
        check("chg_ram_address", ram_address, 16'h0040);
        check("chg_ram_rw", ram_rw, 0);
        wait_release(1'b0);
        check("chg_mem_0x41", mem[16'h0041], 16'h4141);
        a_rw = 1'b0; a_address = '0; a_data_in = '0;

        // Reset during ISSUE of a B write
        e0 = en_count;
        b_rw = 1'b1; b_address = 16'h0030; b_data_in = 16'hAAAA; b_req = 1'b1;
        @(posedge clock); #3;
        check("rstmid_en_before", ram_enable, 1);
        reset_n = 1'b0;
        b_req = 1'b0;
        #1;
        check("rstmid_en_now", ram_enable, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_a_ack", a_ack, 0);
        check("rstmid_b_ack", b_ack, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_a = '0; model_b = '0; held_a = '0; held_b = '0;
        @(negedge clock);
        check("rstmid_mem_0x30", mem[16'h0030], 16'h5555);
        check("rstmid_state", dbg_state, 0);
        check("rstmid_a_data_out", a_data_out, 0);
        check("rstmid_b_data_out", b_data_out, 0);
        check("rstmid_enable_pulses", en_count - e0, 0);
        @(posedge clock); #1;

        // Operation resumes after reset
        access(1'b1, 1'b0, 16'h0051, 16'h0000, 16'h5151, 3);

        repeat (2) @(posedge clock);
        check("pending_a_empty", exp_a_q.size(), 0);
        check("pending_b_empty", exp_b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
